// File: rtl/deb_pkg.sv
// Shared constants and helpers for the input debouncer array.
package deb_pkg;

   localparam int DEB_SYNC_STAGES_DEF   = 2;
   localparam int DEB_STABLE_CYCLES_DEF = 8;

   // The counter must be able to hold values up to STABLE_CYCLES without wrapping.
   function automatic int deb_cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/deb_chan.sv
// One debounced channel: reset-to-idle synchroniser, stability counter and
// registered level plus rise/fall strobes.
module deb_chan
   import deb_pkg::*;
#(
   parameter int   SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
   parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
   parameter logic RESET_LEVEL   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
);

   localparam int            CW       = deb_cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt;

   assign s = sync_q[SYNC_STAGES-1];

   // The synchroniser keeps shifting even while en is low, so re-enabling sees a current level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      end
   end

   // Accept a new level only after STABLE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         out  <= RESET_LEVEL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (!en) begin
            cnt <= '0;
         end else if (s == out) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            out  <= s;
            cnt  <= '0;
            rise <= s;
            fall <= ~s;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/deb_array.sv
// Array of independent debounced channels sharing clock, reset and enable.
module deb_array
   import deb_pkg::*;
#(
   parameter int   CHANNELS      = 2,
   parameter int   SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
   parameter int   STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
   parameter logic RESET_LEVEL   = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      deb_chan #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES),
         .RESET_LEVEL  (RESET_LEVEL)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .en   (en),
         .in   (in[i]),
         .out  (out[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

endmodule

// File: doc/deb_array.md
# deb_array

Multi-channel, parametrised input debouncer/synchroniser for asynchronous board-level lines such as PS/2 clock and data. Each channel synchronises its raw input, then accepts a new level only after it has held for a programmable number of consecutive cycles. It also emits single-cycle rise/fall strobes, so downstream receivers such as the PS/2 frame decoder can sample on a clean falling edge without extra edge-detect logic. It sits directly behind the pad inputs and feeds all keyboard-side logic.

## Interface
- CHANNELS, 2: number of independent lines; ≥1
- SYNC_STAGES, 2: synchroniser flops per channel; ≥2
- STABLE_CYCLES, 8: consecutive synchronised cycles a new level must persist before acceptance; ≥1
- RESET_LEVEL, 1'b1: reset value of every synchroniser flop and every `out` bit (lines idle high)
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  global enable; low freezes outputs and clears counters
- in  input  CHANNELS  raw asynchronous inputs
- out  output  CHANNELS  debounced levels
- rise  output  CHANNELS  one-cycle pulse, cycle in which `out[i]` went 0→1
- fall  output  CHANNELS  one-cycle pulse, cycle in which `out[i]` went 1→0

## Operation
- Reset values:
  - all synchroniser flops = RESET_LEVEL
  - `out` = {CHANNELS{RESET_LEVEL}}
  - `rise` = `fall` = 0
  - counters = 0
- Per channel i, `s` = last synchroniser stage. The synchroniser shifts every cycle regardless of `en`.
- Counter width CW = $clog2(STABLE_CYCLES+1).
- Each cycle with en=1:
  - if `s == out[i]`: cnt ← 0
  - else if `cnt == STABLE_CYCLES-1`: out[i] ← s, cnt ← 0, rise[i]/fall[i] ← 1 according to direction
  - else: cnt ← cnt+1
- Any cycle where `s` returns to `out[i]` clears the count. The count is for consecutive cycles only, and the counter never wraps.
- `rise`/`fall` are registered in the same cycle as `out`. They are high for exactly one cycle and are never both high on one channel.
- en=0: cnt ← 0, `out` holds, `rise`/`fall` ← 0. When en returns high, counting restarts from 0.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobe in the same cycle.
- rst_n asserted mid-count: all state returns to reset values immediately. No strobe is generated by reset or by reset release.

## Timing
- Edge 1 is the first rising edge that samples a new `in` level. `out` changes at rising edge SYNC_STAGES+STABLE_CYCLES, and the strobe is visible in that same cycle.
- Defaults give a latency of 10 cycles.
- A synchronised pulse of exactly STABLE_CYCLES cycles is accepted. A pulse of STABLE_CYCLES-1 cycles is rejected with no strobe.
- No combinational path from `in` to any output.

## Structure
- Shared package `deb_pkg`:
  - default constants DEB_SYNC_STAGES_DEF = 2, DEB_STABLE_CYCLES_DEF = 8
  - the counter width function
- Sub-module `deb_chan`: one channel (synchroniser, counter, out/rise/fall flops), parametrised by SYNC_STAGES, STABLE_CYCLES and RESET_LEVEL.
- `deb_array` is a generate loop of CHANNELS `deb_chan` instances sharing `clk`, `rst_n` and `en`.

## Test plan
All scenarios use CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, en=1 unless noted.
- Reset/idle:
  - During reset, `out`=2'b11 and `rise`=`fall`=0.
  - Release reset with in=2'b11: no strobes for 50 cycles.
- Accept:
  - Drive in[0]=0 and hold it.
  - `out[0]` goes to 0 and `fall[0]`=1 at edge 6, for one cycle only.
  - Return in[0]=1: `rise[0]` pulses 6 edges later.
- Glitch reject:
  - in[0]=0 for 3 cycles, then 1: `out` stays 2'b11 with no strobes.
  - in[0]=0 for exactly 4 cycles: one `fall[0]` followed by one `rise[0]`.
- Chatter:
  - in[1] toggles every 2 cycles for 40 cycles, then settles at 0: exactly one `fall[1]`, 6 edges after settling.
  - `out[0]` is unaffected throughout.
- Enable:
  - en=0, in=2'b00 for 20 cycles: `out` holds 2'b11 with no strobes.
  - Raise en: both `fall` bits pulse together 4 edges later.
- Reset mid-count:
  - After in[0]=0 for 3 synchronised cycles, pulse rst_n low.
  - `out[0]`=1 immediately, with no strobe.
  - After release, `fall[0]` occurs 6 edges after release with in[0] still 0.
